// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor: one full_sub cell plus a registered borrow,
// WIDTH cycles per operation. Optional signed-overflow port via SERIAL_SUB_OVF_EN.

module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic sub,
   output logic bor
);
   assign sub = a ^ b ^ bin;
   assign bor = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, next_state;

   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] r_sh;
   logic             brw;
   logic [CNT_W-1:0] cnt;
   logic             sub, bor;
   logic             accept, last;
   logic [WIDTH-1:0] r_next;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb, b_msb;
`endif

   full_sub u_fs (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .bin (brw),
      .sub (sub),
      .bor (bor)
   );

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
   // The bit leaving r_sh would be discarded, so only WIDTH-1 bits are stored.
   assign r_next = {sub, r_sh};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) next_state = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = start ? RUN : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         r_sh <= '0;
         brw  <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
         brw  <= 1'b0;
         cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         r_sh <= r_next[WIDTH-1:1];
         brw  <= bor;
         cnt  <= cnt + CNT_W'(1);
         // Results are published only on the final bit so diff never shows partial shifts.
         if (last) begin
            diff <= r_next;
            bout <= bor;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (a_msb != b_msb) && (sub != a_msb);
`endif
         end
      end
   end
endmodule

// File: tb/tb_serial_sub.sv
// Randomized self-checking bench for serial_sub (WIDTH=8) against an arithmetic reference.
`timescale 1ns/1ps

module tb_serial_sub;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, bout;
   logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cyc;

   serial_sub #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one subtraction and follow it to its done cycle; returns while done is visible.
   task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input int mid_at, input string tag);
      logic [WIDTH-1:0] ed;
      logic             eb, eo, bad_busy;
      int               sd, lat;
      ed = ta - tb;
      eb = (int'(ta) < int'(tb));
      sd = int'($signed(ta)) - int'($signed(tb));
      eo = (sd < -(2 ** (WIDTH - 1))) || (sd > 2 ** (WIDTH - 1) - 1);
      start = 1'b1; a = ta; b = tb;
      step();
      lat = 0;
      bad_busy = 1'b0;
      while (!done && lat < 40) begin
         if (!busy) bad_busy = 1'b1;
         if (lat == mid_at) begin
            start = 1'b1; a = 8'hFF; b = 8'h00;
         end else begin
            start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
         end
         step();
         lat++;
      end
      start = 1'b0;
      done_cyc = cyc;
      check({tag, " latency"}, lat, WIDTH);
      check({tag, " busy_run"}, bad_busy, 0);
      check({tag, " busy_done"}, busy, 0);
      check({tag, " diff"}, diff, ed);
      check({tag, " bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, " ovf"}, ovf, eo);
`endif
   endtask

   task automatic check_hold(input string tag, input logic [WIDTH-1:0] ed, input logic eb);
      step();
      check({tag, " hold_done"}, done, 0);
      check({tag, " hold_busy"}, busy, 0);
      check({tag, " hold_diff"}, diff, ed);
      check({tag, " hold_bout"}, bout, eb);
   endtask

   initial begin
      int first, seen;
      logic [WIDTH-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b1; a = 8'h5A; b = 8'h23;
      step();
      step();
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst diff", diff, 0);
      check("rst bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst ovf", ovf, 0);
`endif
      rst_n = 1'b1; start = 1'b0;
      step();
      check("post_rst idle", busy, 0);

      do_op(8'h5A, 8'h23, -1, "basic");
      check_hold("basic", 8'h37, 1'b0);
      do_op(8'h00, 8'h01, -1, "borrow");
      check_hold("borrow", 8'hFF, 1'b1);
      do_op(8'hFF, 8'hFF, -1, "equal");
      check_hold("equal", 8'h00, 1'b0);
      do_op(8'h10, 8'h01, 3, "mid_start");
      check_hold("mid_start", 8'h0F, 1'b0);
      do_op(8'h80, 8'h01, -1, "ovf_pos");
      check_hold("ovf_pos", 8'h7F, 1'b0);
      do_op(8'h05, 8'h07, -1, "ovf_neg");
      check_hold("ovf_neg", 8'hFE, 1'b1);

      do_op(8'h20, 8'h11, -1, "b2b_a");
      first = done_cyc;
      do_op(8'h09, 8'h03, -1, "b2b_b");
      check("b2b gap", done_cyc - first, WIDTH + 1);

      start = 1'b1; a = 8'h44; b = 8'h11;
      step();
      start = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort diff", diff, 0);
      check("abort bout", bout, 0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (done || busy) seen++;
         step();
      end
      check("abort quiet", seen, 0);

      for (int i = 0; i < 30; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         do_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 2)) : -1, "rand");
         case ($urandom_range(0, 2))
            0: ;
            1: check_hold("rand", WIDTH'(ra - rb), int'(ra) < int'(rb));
            default: begin
               check_hold("rand", WIDTH'(ra - rb), int'(ra) < int'(rb));
               step();
            end
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
